mc_ctrl: RTL
============

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter ALU_OP_W, default 5, alu_op width; SHALL be >=5; opcodes zero-extended.
REQ-002 Parameter TIMEOUT, default 15, number of consecutive mem_rdy-low wait cycles before abort; range 1..255.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ir31_26  in  6  opcode field; stable from DECODE onward.
REQ-006 ir5_0  in  6  funct field for opcode 000000.
REQ-007 eq  in  1  ALU operands equal.
REQ-008 mem_rdy  in  1  memory access complete this cycle.
REQ-009 ir_we, pc_we  out  1 each  load IR / load PC at the next edge.
REQ-010 rf_we, dm_we, dm_re  out  1 each  register write / data-memory write / memory read.
REQ-011 rf_wa_s  out  1  1 = rt, 0 = rd; rf_wd_s  out  1  1 = ALU result, 0 = memory; add2_s  out  1  1 = register rt, 0 = immediate.
REQ-012 alu_op  out  ALU_OP_W  add=00010, sub=01110, and=00000, or=00001, slt=01111.
REQ-013 pc_s  out  2  00 = PC+4, 01 = jump, 10 = branch.
REQ-014 state  out  3  current state; done, illegal, timeout  out  1 each  one-cycle pulses.

Function
REQ-015 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; outputs are combinational from state, ir31_26, ir5_0, eq and mem_rdy; every output not named for a state is 0.
REQ-016 FETCH: dm_re=1; mem_rdy=1 -> ir_we=1, pc_we=1, pc_s=00, next DECODE; otherwise stay.
REQ-017 DECODE: legal ops (lw 100011, sw 101011, addi 001000, j 000010, beq 000100, R-type 000000 with funct 100000/100010/100100/100101/101010) -> EXEC; all others -> FETCH with illegal=1 and no writes.
REQ-018 EXEC lw/sw: alu_op=add, add2_s=0 -> MEM.
REQ-019 EXEC addi: alu_op=add, add2_s=0 -> WB; EXEC R-type: add2_s=1, alu_op per funct -> WB.
REQ-020 EXEC j: pc_we=1, pc_s=01, done=1 -> FETCH.
REQ-021 EXEC beq: alu_op=sub, add2_s=1, done=1 -> FETCH; eq=1 -> pc_we=1, pc_s=10; eq=0 -> pc_we=0, pc_s=00.
REQ-022 MEM lw: dm_re=1, alu_op=add; mem_rdy=1 -> WB; otherwise stay.
REQ-023 MEM sw: dm_we=1, alu_op=add, held until mem_rdy=1 -> done=1, next FETCH.
REQ-024 WB: rf_we=1, done=1 -> FETCH; lw: rf_wa_s=1, rf_wd_s=0; addi: rf_wa_s=1, rf_wd_s=1; R-type: rf_wa_s=0, rf_wd_s=1; alu_op repeats the EXEC value.
REQ-025 Latency with mem_rdy always 1: lw 5 cycles, sw/addi/R-type 4, beq/j 3, FETCH to done inclusive.
REQ-026 illegal, timeout and done SHALL never assert in the same cycle.

Reset
REQ-027 rst=1 at an edge SHALL force state=FETCH and wait counter=0, overriding any transition, including one in progress in MEM.
REQ-028 In the reset cycle the outputs SHALL take their FETCH values (dm_re=1, all others 0 unless mem_rdy=1).

Configuration
REQ-029 Macro MC_CTRL_TIMEOUT_EN. Defined: an 8-bit wait counter clears on entry to FETCH or MEM and increments each wait cycle with mem_rdy=0. On the TIMEOUT-th consecutive such cycle, timeout=1 and all write enables are 0 that cycle; next state FETCH.
REQ-030 mem_rdy=1 in the same cycle as the timeout condition SHALL win, giving a normal completion.
REQ-031 Macro undefined: no counter, timeout tied 0, waits are unbounded.

Verification
REQ-032 rst 1 cycle, mem_rdy=1, lw -> states 0,1,2,3,4; WB: rf_we=1, rf_wa_s=1, rf_wd_s=0, alu_op=00010; done in cycle 5.
REQ-033 sub (000000/100010), mem_rdy=1 -> EXEC alu_op=01110, add2_s=1; WB rf_we=1, rf_wa_s=0, rf_wd_s=1; done in cycle 4.
REQ-034 beq with eq=1 -> EXEC pc_we=1, pc_s=10, alu_op=01110; then beq with eq=0 -> pc_we=0, pc_s=00; both done in cycle 3.
REQ-035 sw with mem_rdy low 3 MEM cycles then high -> dm_we=1 for 4 cycles, done on the 4th, next FETCH.
REQ-036 Opcode 111111 -> DECODE illegal=1, no writes, next FETCH; rst asserted while in MEM -> FETCH next cycle.
REQ-037 With MC_CTRL_TIMEOUT_EN defined, TIMEOUT=3, mem_rdy held 0 in MEM for lw -> timeout=1 on the 3rd wait cycle, rf_we never 1, next FETCH.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset control FSM (FETCH, DECODE, EXEC, MEM, WB).
// Defining MC_CTRL_TIMEOUT_EN adds a memory-wait counter that aborts after TIMEOUT cycles.
module mc_ctrl #(
  parameter int unsigned ALU_OP_W = 5,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          ir31_26,
  input  logic [5:0]          ir5_0,
  input  logic                eq,
  input  logic                mem_rdy,
  output logic                ir_we,
  output logic                pc_we,
  output logic                rf_we,
  output logic                dm_we,
  output logic                dm_re,
  output logic                rf_wa_s,
  output logic                rf_wd_s,
  output logic                add2_s,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          pc_s,
  output logic [2:0]          state,
  output logic                done,
  output logic                illegal,
  output logic                timeout
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;

  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b01110;
  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_SLT = 5'b01111;

  logic [2:0] state_q, state_d, cur;
  logic [4:0] alu5, fn_alu;
  logic       is_lw, is_sw, is_addi, is_j, is_beq, is_r, r_ok, legal;
  logic       to_hit;

  assign is_lw   = (ir31_26 == 6'b100011);
  assign is_sw   = (ir31_26 == 6'b101011);
  assign is_addi = (ir31_26 == 6'b001000);
  assign is_j    = (ir31_26 == 6'b000010);
  assign is_beq  = (ir31_26 == 6'b000100);
  assign is_r    = (ir31_26 == 6'b000000);

  always_comb begin
    r_ok   = 1'b1;
    fn_alu = ALU_ADD;
    case (ir5_0)
      6'b100000: fn_alu = ALU_ADD;
      6'b100010: fn_alu = ALU_SUB;
      6'b100100: fn_alu = ALU_AND;
      6'b100101: fn_alu = ALU_OR;
      6'b101010: fn_alu = ALU_SLT;
      default:   r_ok   = 1'b0;
    endcase
  end

  assign legal = is_lw | is_sw | is_addi | is_j | is_beq | (is_r & r_ok);

  // While rst is high the outputs decode as FETCH, whatever state_q holds.
  assign cur   = rst ? FETCH : state_q;
  assign state = cur;

`ifdef MC_CTRL_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       wait_cyc;

  assign wait_cyc = !mem_rdy && ((cur == FETCH) || (cur == MEM));
  assign to_hit   = wait_cyc && !rst && (cnt_q == 8'(TIMEOUT - 1));
  assign cnt_d    = (wait_cyc && !to_hit) ? cnt_q + 8'd1 : '0;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = FETCH;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    rf_we   = 1'b0;
    dm_we   = 1'b0;
    dm_re   = 1'b0;
    rf_wa_s = 1'b0;
    rf_wd_s = 1'b0;
    add2_s  = 1'b0;
    alu5    = '0;
    pc_s    = 2'b00;
    done    = 1'b0;
    illegal = 1'b0;
    timeout = 1'b0;
    case (cur)
      FETCH: begin
        dm_re = 1'b1;
        if (mem_rdy) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (legal) state_d = EXEC;
        else       illegal = 1'b1;
      end
      EXEC: begin
        if (is_lw || is_sw) begin
          alu5    = ALU_ADD;
          state_d = MEM;
        end else if (is_addi) begin
          alu5    = ALU_ADD;
          state_d = WB;
        end else if (is_r) begin
          add2_s  = 1'b1;
          alu5    = fn_alu;
          state_d = WB;
        end else if (is_j) begin
          pc_we = 1'b1;
          pc_s  = 2'b01;
          done  = 1'b1;
        end else if (is_beq) begin
          alu5   = ALU_SUB;
          add2_s = 1'b1;
          done   = 1'b1;
          pc_we  = eq;
          pc_s   = eq ? 2'b10 : 2'b00;
        end
      end
      MEM: begin
        alu5 = ALU_ADD;
        if (is_lw) begin
          dm_re   = 1'b1;
          state_d = mem_rdy ? WB : MEM;
        end else if (is_sw) begin
          dm_we   = 1'b1;
          done    = mem_rdy;
          state_d = mem_rdy ? FETCH : MEM;
        end
      end
      WB: begin
        rf_we   = 1'b1;
        done    = 1'b1;
        rf_wa_s = !is_r;
        rf_wd_s = !is_lw;
        alu5    = is_r ? fn_alu : ALU_ADD;
      end
      default: state_d = FETCH;
    endcase
    if (to_hit) begin
      timeout = 1'b1;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      rf_we   = 1'b0;
      dm_we   = 1'b0;
      state_d = FETCH;
    end
  end

  assign alu_op = ALU_OP_W'(alu5);

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

endmodule
